// File: rtl/rvvi_retire_queue_if.sv
// -----------------------------------------------------------------------------
// rvvi_retire_queue_if
// Bundles the RVVI retire-side and consumer-side signals of rvvi_retire_queue.
//   slave  modport : used by the queue itself
//   master modport : used by whatever drives the retire lanes / consumes records
// Retire side : in_valid[NRET], in_pc[NRET*XLEN], in_insn[NRET*32], in_trap[NRET]
// Consumer    : out_valid, out_ready, out_pc, out_insn, out_trap, out_order
// Status      : count, overflow, drop_count, clear_overflow
// Optional    : out_cycle[31:0] when RVVI_RETIRE_QUEUE_TIMESTAMP_EN is defined.
// -----------------------------------------------------------------------------
interface rvvi_retire_queue_if #(
   parameter int XLEN  = 64,
   parameter int NRET  = 2,
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [NRET-1:0]      in_valid;
   logic [NRET*XLEN-1:0] in_pc;
   logic [NRET*32-1:0]   in_insn;
   logic [NRET-1:0]      in_trap;

   logic                 out_valid;
   logic                 out_ready;
   logic [XLEN-1:0]      out_pc;
   logic [31:0]          out_insn;
   logic                 out_trap;
   logic [63:0]          out_order;

   logic [CW-1:0]        count;
   logic                 overflow;
   logic [15:0]          drop_count;
   logic                 clear_overflow;

`ifdef RVVI_RETIRE_QUEUE_TIMESTAMP_EN
   logic [31:0]          out_cycle;

   modport slave (
      input  in_valid, in_pc, in_insn, in_trap, out_ready, clear_overflow,
      output out_valid, out_pc, out_insn, out_trap, out_order,
             count, overflow, drop_count, out_cycle
   );

   modport master (
      output in_valid, in_pc, in_insn, in_trap, out_ready, clear_overflow,
      input  out_valid, out_pc, out_insn, out_trap, out_order,
             count, overflow, drop_count, out_cycle
   );
`else
   modport slave (
      input  in_valid, in_pc, in_insn, in_trap, out_ready, clear_overflow,
      output out_valid, out_pc, out_insn, out_trap, out_order,
             count, overflow, drop_count
   );

   modport master (
      output in_valid, in_pc, in_insn, in_trap, out_ready, clear_overflow,
      input  out_valid, out_pc, out_insn, out_trap, out_order,
             count, overflow, drop_count
   );
`endif

endinterface

// File: rtl/rvvi_retire_queue.sv
// -----------------------------------------------------------------------------
// rvvi_retire_queue
// Buffers up to NRET retired-instruction records per cycle from the core's
// RVVI port and presents them one at a time, in program order, to a coverage
// sampler (first-word fall-through, valid/ready). Every retire, accepted or
// dropped, consumes one 64-bit order number, so drops show up as gaps in
// out_order. The core is never stalled: lanes that do not fit are dropped and
// recorded in a sticky overflow flag and a saturating 16-bit drop counter.
//
// Ports
//   clk    : clock
//   reset  : asynchronous active-high reset, discards all queued entries
//   q_if   : rvvi_retire_queue_if.slave (retire lanes, head record, status)
//
// Optional feature macro: RVVI_RETIRE_QUEUE_TIMESTAMP_EN
//   When defined, each accepted record also stores a free-running 32-bit
//   cycle count, presented on q_if.out_cycle.
// -----------------------------------------------------------------------------
module rvvi_retire_queue #(
   parameter int XLEN  = 64,
   parameter int NRET  = 2,
   parameter int DEPTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   rvvi_retire_queue_if.slave  q_if
);

   localparam int PW = $clog2(DEPTH);        // pointer width, DEPTH is a power of 2
   localparam int CW = $clog2(DEPTH + 1);    // occupancy width, holds 0..DEPTH
   localparam int LW = $clog2(NRET + 1);     // per-cycle lane count width

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     insn;
      logic            trap;
      logic [63:0]     order;
`ifdef RVVI_RETIRE_QUEUE_TIMESTAMP_EN
      logic [31:0]     cycle;
`endif
   } entry_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   head_q,  head_d;
   logic [PW-1:0]   tail_q,  tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic [63:0]     order_q, order_d;
   logic            ovf_q,   ovf_d;
   logic [15:0]     drop_q,  drop_d;
`ifdef RVVI_RETIRE_QUEUE_TIMESTAMP_EN
   logic [31:0]     cyc_q,   cyc_d;
`endif

   // ---------------------------------------------------------------------------
   // Per-cycle enqueue decisions
   // ---------------------------------------------------------------------------
   logic                      out_valid;
   logic                      deq;
   logic [CW-1:0]             free;
   logic [CW-1:0]             n_acc;     // lanes accepted so far this cycle
   logic [LW-1:0]             n_drop;    // lanes dropped so far this cycle
   logic [LW-1:0]             n_seen;    // valid lanes seen so far this cycle
   logic [NRET-1:0]           wr_en;
   logic [NRET-1:0][PW-1:0]   wr_ptr;
   entry_t [NRET-1:0]         wr_data;
   logic [16:0]               drop_sum;
   entry_t                    head_e;

   assign out_valid = (count_q != '0);

   // NOTE: n_acc/n_drop/n_seen are running tallies across the lane loop, so
   // they use blocking assignments here; every variable gets a default first
   // so no path through the block can infer a latch.
   always_comb begin
      deq     = out_valid && q_if.out_ready;
      // A same-cycle dequeue frees one slot for this cycle's enqueue.
      free    = CW'(DEPTH) - count_q + CW'(deq);
      n_acc   = '0;
      n_drop  = '0;
      n_seen  = '0;
      wr_en   = '0;
      wr_ptr  = '0;
      wr_data = '0;

      // Valid lanes are compacted into consecutive tail slots in lane order;
      // once free slots run out the remaining valid lanes are dropped, but
      // they still consume an order number.
      for (int i = 0; i < NRET; i++) begin
         if (q_if.in_valid[i]) begin
            wr_data[i].pc    = q_if.in_pc[i*XLEN +: XLEN];
            wr_data[i].insn  = q_if.in_insn[i*32 +: 32];
            wr_data[i].trap  = q_if.in_trap[i];
            wr_data[i].order = order_q + 64'(n_seen);
`ifdef RVVI_RETIRE_QUEUE_TIMESTAMP_EN
            wr_data[i].cycle = cyc_q;
`endif
            if (n_acc < free) begin
               wr_en[i]  = 1'b1;
               wr_ptr[i] = tail_q + PW'(n_acc);
               n_acc     = n_acc + CW'(1);
            end else begin
               n_drop    = n_drop + LW'(1);
            end
            n_seen = n_seen + LW'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      head_d   = head_q + PW'(deq);
      tail_d   = tail_q + PW'(n_acc);
      count_d  = count_q + n_acc - CW'(deq);
      order_d  = order_q + 64'(n_seen);
      ovf_d    = ovf_q;
      drop_d   = drop_q;
      drop_sum = '0;

      // A drop in the same cycle as clear_overflow wins: the counter restarts
      // from this cycle's drops rather than being zeroed.
      if (n_drop != '0) begin
         drop_sum = (q_if.clear_overflow ? 17'd0 : {1'b0, drop_q}) + 17'(n_drop);
         drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         ovf_d    = 1'b1;
      end else if (q_if.clear_overflow) begin
         drop_d   = '0;
         ovf_d    = 1'b0;
      end
   end

`ifdef RVVI_RETIRE_QUEUE_TIMESTAMP_EN
   assign cyc_d = cyc_q + 32'd1;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values computed above.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         order_q <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
`ifdef RVVI_RETIRE_QUEUE_TIMESTAMP_EN
         cyc_q   <= '0;
`endif
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         order_q <= order_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
`ifdef RVVI_RETIRE_QUEUE_TIMESTAMP_EN
         cyc_q   <= cyc_d;
`endif
      end
   end

   // NOTE: the storage array is deliberately not reset; an entry is only ever
   // read while count != 0, i.e. after it has been written, and the outputs
   // are forced to 0 when empty. This keeps the array mappable to plain RAM.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NRET; i++) begin
         if (wr_en[i]) begin
            mem_q[wr_ptr[i]] <= wr_data[i];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Head presentation (first-word fall-through, zero when empty)
   // ---------------------------------------------------------------------------
   assign head_e         = mem_q[head_q];
   assign q_if.out_valid = out_valid;
   assign q_if.out_pc    = out_valid ? head_e.pc    : '0;
   assign q_if.out_insn  = out_valid ? head_e.insn  : '0;
   assign q_if.out_trap  = out_valid ? head_e.trap  : 1'b0;
   assign q_if.out_order = out_valid ? head_e.order : '0;
`ifdef RVVI_RETIRE_QUEUE_TIMESTAMP_EN
   assign q_if.out_cycle = out_valid ? head_e.cycle : '0;
`endif

   assign q_if.count      = count_q;
   assign q_if.overflow   = ovf_q;
   assign q_if.drop_count = drop_q;

endmodule
